// File: rtl/snn_ctrl_pkg.sv
// Shared types and constants for the SNN image loader / sequencer.
// Reply format selected by SNN_ASCII_EN.
package snn_ctrl_pkg;

  localparam int         NUM_BITS_DFLT = 784;
  localparam int         ADDR_W        = 10;
  localparam logic [7:0] ASCII_ZERO    = 8'h30;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    SEND
  } state_e;

  function automatic logic [7:0] fmt_digit(
    input logic [3:0] d,
    input logic       ascii
  );
    return ascii ? ASCII_ZERO + {4'b0, d} : {4'b0, d};
  endfunction

endpackage

// File: rtl/snn_load_ctrl_if.sv
// UART-rx, input-RAM, SNN-core and UART-tx signals of the loader.
// master = loader side, slave = surrounding system.
interface snn_load_ctrl_if;
  import snn_ctrl_pkg::*;

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_data;
  logic [ADDR_W-1:0] core_addr;
  logic              core_start;
  logic              core_done;
  logic [3:0]        core_digit;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;

  modport master (
    input  rx_valid, rx_data, core_addr,
    input  core_done, core_digit, tx_busy,
    output ram_we, ram_addr, ram_data,
    output core_start, tx_start, tx_data
  );

  modport slave (
    output rx_valid, rx_data, core_addr,
    output core_done, core_digit, tx_busy,
    input  ram_we, ram_addr, ram_data,
    input  core_start, tx_start, tx_data
  );

endinterface

// File: rtl/snn_byte_unpack.sv
// Serialises received bytes LSB first, with a one-byte holding
// register and sticky overrun detection.
module snn_byte_unpack (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       flush_i,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i,
  output logic       wr_o,
  output logic       bit_o,
  output logic       ovr_o
);

  logic [7:0] sh_q, sh_d;
  logic [7:0] hold_q, hold_d;
  logic [2:0] idx_q, idx_d;
  logic       act_q, act_d;
  logic       hv_q, hv_d;
  logic       ovr_q, ovr_d;
  logic       last;

  assign last = act_q && (idx_q == 3'd7);

  always_comb begin
    sh_d   = sh_q;
    hold_d = hold_q;
    idx_d  = idx_q;
    act_d  = act_q;
    hv_d   = hv_q;
    ovr_d  = ovr_q;
    if (act_q) begin
      sh_d  = sh_q >> 1;
      idx_d = idx_q + 3'd1;
    end
    if (last) begin
      if (hv_q) begin
        sh_d = hold_q;
        hv_d = 1'b0;
      end else begin
        act_d = 1'b0;
      end
    end
    // A draining holding register frees its slot in the same cycle
    if (rx_valid_i) begin
      if (!en_i) begin
        ovr_d = 1'b1;
      end else if (!act_q || (last && !hv_q)) begin
        sh_d  = rx_data_i;
        act_d = 1'b1;
      end else if (!hv_q || last) begin
        hold_d = rx_data_i;
        hv_d   = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
    if (flush_i) begin
      act_d = 1'b0;
      hv_d  = 1'b0;
      idx_d = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_q   <= 8'h00;
      hold_q <= 8'h00;
      idx_q  <= 3'd0;
      act_q  <= 1'b0;
      hv_q   <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      hold_q <= hold_d;
      idx_q  <= idx_d;
      act_q  <= act_d;
      hv_q   <= hv_d;
      ovr_q  <= ovr_d;
    end
  end

  assign wr_o  = act_q;
  assign bit_o = sh_q[0];
  assign ovr_o = ovr_q;

endmodule

// File: rtl/snn_load_ctrl.sv
// Loads a 1-bpp image from UART into the input RAM, runs the SNN
// core and replies with the digit. SNN_ASCII_EN: ASCII reply.
module snn_load_ctrl
  import snn_ctrl_pkg::*;
#(
  parameter int NUM_BITS = NUM_BITS_DFLT,
  parameter int BYTES    = NUM_BITS_DFLT / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  snn_load_ctrl_if.master   bus,
  output logic              busy,
  output logic              ovr
);

  localparam int ImgBits =
    (BYTES * 8 < NUM_BITS) ? BYTES * 8 : NUM_BITS;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(ImgBits - 1);

`ifdef SNN_ASCII_EN
  localparam logic AsciiEn = 1'b1;
`else
  localparam logic AsciiEn = 1'b0;
`endif

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [7:0]        tx_data_q;
  logic              wr;
  logic              wbit;
  logic              rx_en;
  logic              flush;
  logic              core_phase;

  assign rx_en = (state_q == IDLE) || (state_q == LOAD);
  assign flush = (state_q == LOAD) && wr && (cnt_q == LastAddr);
  assign core_phase = (state_q == START) || (state_q == WAIT);

  snn_byte_unpack u_unpack (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (rx_en),
    .flush_i    (flush),
    .rx_valid_i (bus.rx_valid),
    .rx_data_i  (bus.rx_data),
    .wr_o       (wr),
    .bit_o      (wbit),
    .ovr_o      (ovr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tx_data_q <= 8'h00;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.rx_valid) state_q <= LOAD;
        end
        LOAD: begin
          if (wr) begin
            if (cnt_q == LastAddr) begin
              cnt_q   <= '0;
              state_q <= START;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        START: state_q <= WAIT;
        WAIT: begin
          if (bus.core_done) begin
            tx_data_q <= fmt_digit(bus.core_digit, AsciiEn);
            state_q   <= SEND;
          end
        end
        SEND: begin
          if (!bus.tx_busy) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The core owns the RAM address while it runs
  assign bus.ram_addr   = core_phase ? bus.core_addr : cnt_q;
  assign bus.ram_we     = wr;
  assign bus.ram_data   = wr & wbit;
  assign bus.core_start = (state_q == START);
  assign bus.tx_start   = (state_q == SEND) && !bus.tx_busy;
  assign bus.tx_data    = tx_data_q;
  assign busy           = (state_q != IDLE);

endmodule
